// File: rtl/ram2p1r1wbe_128x64_arb.sv
// 128x64 two-port RAM front end: round-robin arbitration of two byte-masked writers onto
// port B, one reader on port A. Optional power-up clear sequencer under RAM2P_CLEAR_EN.
module ram2p1r1wbe_128x64_arb (
   input  logic        clk,
   input  logic        reset,
   input  logic        w0_req,
   input  logic [6:0]  w0_adr,
   input  logic [63:0] w0_data,
   input  logic [7:0]  w0_byteen,
   output logic        w0_gnt,
   input  logic        w1_req,
   input  logic [6:0]  w1_adr,
   input  logic [63:0] w1_data,
   input  logic [7:0]  w1_byteen,
   output logic        w1_gnt,
   input  logic        rd_req,
   input  logic [6:0]  rd_adr,
   output logic        rd_gnt,
   output logic        rd_valid,
   output logic [63:0] rd_data,
   output logic        busy,
   output logic        ceba,
   output logic        weba,
   output logic [6:0]  aa,
   output logic [63:0] da,
   output logic [63:0] bweba,
   input  logic [63:0] qa,
   output logic        cebb,
   output logic        webb,
   output logic [6:0]  ab,
   output logic [63:0] db,
   output logic [63:0] bwebb
);

   localparam int unsigned AW = 7;
   localparam int unsigned DW = 64;
   localparam int unsigned NB = 8;

   logic          in_idle;
   logic          clearing;
   logic [AW-1:0] clr_adr;
   logic          ptr;
   logic          wr_gnt;
   logic [AW-1:0] wr_adr;
   logic [DW-1:0] wr_data;
   logic [NB-1:0] wr_be;
   logic [DW-1:0] wr_mask;

`ifdef RAM2P_CLEAR_EN
   typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;
   state_t        state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Clear walks every address once, the counter wrapping back to 0 on exit
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clearing  = 1'b0;
      case (state)
         CLEAR: begin
            clearing = ~reset;
            cnt_nxt  = cnt + AW'(1);
            if (cnt == AW'(DW'(127))) state_nxt = IDLE;
         end
         IDLE: ;
      endcase
   end

   assign in_idle = (state == IDLE) & ~reset;
   assign busy    = (state == CLEAR);
   assign clr_adr = cnt;
`else
   assign clearing = 1'b0;
   assign in_idle  = ~reset;
   assign busy     = 1'b0;
   assign clr_adr  = '0;
`endif

   // Round-robin write grant, then read grant unless it hits the granted write address
   always_comb begin
      w0_gnt  = in_idle & w0_req & (~w1_req | ~ptr);
      w1_gnt  = in_idle & w1_req & (~w0_req | ptr);
      wr_gnt  = w0_gnt | w1_gnt;
      wr_adr  = w1_gnt ? w1_adr    : w0_adr;
      wr_data = w1_gnt ? w1_data   : w0_data;
      wr_be   = w1_gnt ? w1_byteen : w0_byteen;
      wr_mask = '1;
      for (int b = 0; b < int'(NB); b++) begin
         wr_mask[b*8 +: 8] = {8{~wr_be[b]}};
      end
      rd_gnt  = in_idle & rd_req & ~(wr_gnt & (wr_adr == rd_adr));
   end

   // Port B: clear writes, granted writes, or idle; an all-zero mask keeps the macro idle
   always_comb begin
      cebb  = 1'b1;
      ab    = '0;
      db    = '0;
      bwebb = '1;
      if (clearing) begin
         cebb  = 1'b0;
         ab    = clr_adr;
         bwebb = '0;
      end else if (wr_gnt) begin
         cebb  = ~|wr_be;
         ab    = wr_adr;
         db    = wr_data;
         bwebb = wr_mask;
      end
      webb = cebb;
   end

   assign ceba    = ~rd_gnt;
   assign weba    = 1'b1;
   assign aa      = rd_adr;
   assign da      = '0;
   assign bweba   = '1;
   assign rd_data = rd_valid ? qa : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr      <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         if (wr_gnt) ptr <= w0_gnt;
         rd_valid <= rd_gnt;
      end
   end

endmodule

// File: tb/tb_ram2p1r1wbe_128x64_arb.sv
// Scoreboard bench for ram2p1r1wbe_128x64_arb with a behavioural RAM on ports A/B.
// Covers the clear sequencer as well when built with RAM2P_CLEAR_EN.
module tb_ram2p1r1wbe_128x64_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        w0_req, w1_req, rd_req;
   logic [6:0]  w0_adr, w1_adr, rd_adr;
   logic [63:0] w0_data, w1_data;
   logic [7:0]  w0_byteen, w1_byteen;
   logic        w0_gnt, w1_gnt, rd_gnt, rd_valid, busy;
   logic [63:0] rd_data;
   logic        ceba, weba, cebb, webb;
   logic [6:0]  aa, ab;
   logic [63:0] da, bweba, db, bwebb;
   logic [63:0] qa;

   bit [63:0]   ram_mem [128];
   bit [63:0]   ref_mem [128];
   logic [63:0] exp_q [$];
   logic [63:0] mon_exp;
   bit          m_ptr;
   bit          mon_en;
   int          n_chk, n_err;

   always #5 clk = ~clk;

   ram2p1r1wbe_128x64_arb dut (
      .clk(clk), .reset(reset),
      .w0_req(w0_req), .w0_adr(w0_adr), .w0_data(w0_data), .w0_byteen(w0_byteen), .w0_gnt(w0_gnt),
      .w1_req(w1_req), .w1_adr(w1_adr), .w1_data(w1_data), .w1_byteen(w1_byteen), .w1_gnt(w1_gnt),
      .rd_req(rd_req), .rd_adr(rd_adr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .busy(busy),
      .ceba(ceba), .weba(weba), .aa(aa), .da(da), .bweba(bweba), .qa(qa),
      .cebb(cebb), .webb(webb), .ab(ab), .db(db), .bwebb(bwebb)
   );

   // Behavioural macro: port B masked write, port A registered read
   always @(posedge clk) begin
      if (!cebb && !webb) ram_mem[ab] <= (ram_mem[ab] & bwebb) | (db & ~bwebb);
      if (!ceba) qa <= ram_mem[aa];
   end

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] mask_of(input logic [7:0] be);
      logic [63:0] m;
      for (int b = 0; b < 8; b++) m[b*8 +: 8] = be[b] ? 8'h00 : 8'hFF;
      return m;
   endfunction

   // Monitor: every valid read must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) chk1("rd_valid_unexpected", rd_valid, 1'b0);
            else begin
               mon_exp = exp_q.pop_front();
               chk64("rd_data", rd_data, mon_exp);
            end
         end else begin
            chk64("rd_data_idle", rd_data, 64'h0);
         end
      end
   end

   // One IDLE-state cycle: drive, predict grants from the rules, update the reference memory
   task automatic cycle(input bit r0, input bit [6:0] a0, input bit [63:0] d0, input bit [7:0] b0,
                        input bit r1, input bit [6:0] a1, input bit [63:0] d1, input bit [7:0] b1,
                        input bit rr, input bit [6:0] ra);
      bit g0, g1, gw, eg;
      bit [6:0]  wa;
      bit [63:0] wd;
      bit [7:0]  wb;
      @(negedge clk);
      w0_req = r0; w0_adr = a0; w0_data = d0; w0_byteen = b0;
      w1_req = r1; w1_adr = a1; w1_data = d1; w1_byteen = b1;
      rd_req = rr; rd_adr = ra;
      #1;
      g0 = r0 && (!r1 || !m_ptr);
      g1 = r1 && !g0;
      gw = g0 || g1;
      wa = g1 ? a1 : a0;
      wd = g1 ? d1 : d0;
      wb = g1 ? b1 : b0;
      eg = rr && !(gw && wa == ra);
      chk1("w0_gnt", w0_gnt, g0);
      chk1("w1_gnt", w1_gnt, g1);
      chk1("rd_gnt", rd_gnt, eg);
      chk1("ceba", ceba, !eg);
      chk64("porta_static", 64'({weba, &bweba, |da}), 64'b110);
      if (eg) begin
         chk64("aa", 64'(aa), 64'(ra));
         exp_q.push_back(ref_mem[ra]);
      end
      if (gw && wb != 8'h00) begin
         chk1("cebb_wr", cebb, 1'b0);
         chk1("webb_wr", webb, 1'b0);
         chk64("ab", 64'(ab), 64'(wa));
         chk64("db", db, wd);
         chk64("bwebb", bwebb, mask_of(wb));
      end else begin
         chk1("cebb_idle", cebb, 1'b1);
      end
      if (gw) begin
         for (int b = 0; b < 8; b++) if (wb[b]) ref_mem[wa][b*8 +: 8] = wd[b*8 +: 8];
         m_ptr = g0;
      end
   endtask

   task automatic idle_cycle();
      cycle(0, 7'd0, 64'd0, 8'd0, 0, 7'd0, 64'd0, 8'd0, 0, 7'd0);
   endtask

`ifdef RAM2P_CLEAR_EN
   // Called at the negedge reset drops; checks the sweep, optionally stopping early
   task automatic clear_seq(input int stop_at);
      w0_req = 1'b1; w1_req = 1'b1; rd_req = 1'b1;
      w0_byteen = 8'hFF; w1_byteen = 8'hFF;
      #1;
      for (int i = 0; i < 128; i++) begin
         if (i == stop_at) return;
         chk1("clr_busy", busy, 1'b1);
         chk64("clr_ab", 64'(ab), 64'(i));
         chk64("clr_ctl", 64'({cebb, webb, |db, |bwebb, w0_gnt, w1_gnt, rd_gnt}), 64'h0);
         @(negedge clk);
         #1;
      end
      chk1("clr_done_busy", busy, 1'b0);
      w0_req = 1'b0; w1_req = 1'b0; rd_req = 1'b0;
      for (int a = 0; a < 128; a++) ref_mem[a] = 64'h0;
   endtask
`endif

   // Reset assertion with requests pending: no grants, no read data, macro idle
   task automatic reset_checks();
      w0_req = 1'b1; w1_req = 1'b1; rd_req = 1'b1;
      w0_byteen = 8'hFF; w1_byteen = 8'hFF;
      #1;
      chk1("rst_w0_gnt", w0_gnt, 1'b0);
      chk1("rst_w1_gnt", w1_gnt, 1'b0);
      chk1("rst_rd_gnt", rd_gnt, 1'b0);
      chk1("rst_rd_valid", rd_valid, 1'b0);
      chk64("rst_rd_data", rd_data, 64'h0);
      chk1("rst_cebb", cebb, 1'b1);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0;
      m_ptr = 1'b0;
`ifdef RAM2P_CLEAR_EN
      clear_seq(128);
`else
      w0_req = 1'b0; w1_req = 1'b0; rd_req = 1'b0;
      #1;
      chk1("noclr_busy", busy, 1'b0);
`endif
   endtask

   initial begin
      bit [7:0]  rb0, rb1;
      bit [63:0] d9;
      n_chk = 0; n_err = 0; mon_en = 1'b0;
      reset = 1'b1;
      w0_req = 0; w0_adr = 0; w0_data = 0; w0_byteen = 0;
      w1_req = 0; w1_adr = 0; w1_data = 0; w1_byteen = 0;
      rd_req = 0; rd_adr = 0;
      repeat (2) @(negedge clk);
      reset_checks();
      mon_en = 1'b1;
      release_reset();

      // Freshly cleared (or untouched) word reads back as the model holds it
      cycle(0, 7'd0, 64'd0, 8'd0, 0, 7'd0, 64'd0, 8'd0, 1, 7'd5);
      // Both writers requesting: W0, W1, W0, W1
      for (int k = 0; k < 4; k++)
         cycle(1, 7'(100 + k), {$urandom, $urandom}, 8'hFF, 1, 7'(110 + k), {$urandom, $urandom}, 8'hFF, 0, 7'd0);
      // Zero byte mask still grants and moves the pointer to W1
      cycle(1, 7'd20, {$urandom, $urandom}, 8'h00, 0, 7'd0, 64'd0, 8'd0, 0, 7'd0);
      cycle(1, 7'd21, {$urandom, $urandom}, 8'hFF, 1, 7'd22, {$urandom, $urandom}, 8'hFF, 0, 7'd0);
      chk1("ptr_after_zero_mask", w1_gnt, 1'b1);
      // Single-byte write over the existing word
      cycle(0, 7'd0, 64'd0, 8'd0, 1, 7'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 0, 7'd0);
      chk64("bytemask_bwebb", bwebb, 64'hFFFF_FFFF_FFFF_FF00);
      cycle(0, 7'd0, 64'd0, 8'd0, 0, 7'd0, 64'd0, 8'd0, 1, 7'd3);
      // Read colliding with a write: denied, then retried for the new data
      d9 = {$urandom, $urandom};
      cycle(1, 7'd9, d9, 8'hFF, 0, 7'd0, 64'd0, 8'd0, 1, 7'd9);
      chk1("collision_rd_gnt", rd_gnt, 1'b0);
      cycle(0, 7'd0, 64'd0, 8'd0, 0, 7'd0, 64'd0, 8'd0, 1, 7'd9);
      chk1("retry_rd_gnt", rd_gnt, 1'b1);
      // Back-to-back reads
      for (int k = 0; k < 4; k++) cycle(0, 7'd0, 64'd0, 8'd0, 0, 7'd0, 64'd0, 8'd0, 1, 7'(k + 1));
      idle_cycle();

      // Random traffic on a small address window to provoke collisions
      for (int n = 0; n < 1500; n++) begin
         rb0 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         rb1 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         cycle(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), {$urandom, $urandom}, rb0,
               1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), {$urandom, $urandom}, rb1,
               1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)));
      end
      repeat (2) idle_cycle();

      // Reset while a read is in flight: data must never appear
      cycle(0, 7'd0, 64'd0, 8'd0, 0, 7'd0, 64'd0, 8'd0, 1, 7'd7);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      reset_checks();
      release_reset();

`ifdef RAM2P_CLEAR_EN
      // Reset in the middle of the sweep restarts it from address 0
      cycle(1, 7'd40, {$urandom, $urandom}, 8'hFF, 0, 7'd0, 64'd0, 8'd0, 0, 7'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_ptr = 1'b0;
      clear_seq(60);
      reset = 1'b1;
      reset_checks();
      release_reset();
      cycle(0, 7'd0, 64'd0, 8'd0, 0, 7'd0, 64'd0, 8'd0, 1, 7'd40);
`endif
      for (int n = 0; n < 200; n++) begin
         cycle(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom),
               1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom),
               1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)));
      end
      repeat (3) idle_cycle();
      chk64("reads_outstanding", 64'(exp_q.size()), 64'h0);
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
